uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
- Standalone receive-side engine for the team's UART link.
- Deserialises the asynchronous line (idle-high, start bit, LSB-first data, 1..2 stop bits) using 16x oversampling from an internal baud tick counter.
- Presents each good word through a one-entry holding register with valid/read handshake.
- Reports framing and overrun errors. Drops in wherever a UART's `rx` pin lands, e.g. on the `tx` of a peer UART.

Parameters:
- value_bit, 10, width of the baud divisor input `final_value`.
- bit, 8, data bits per frame (legal 5..9).
- sb, 2, stop bits per frame (legal 1 or 2).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, asynchronous to clk, idle high
- final_value  input  value_bit  tick divisor; one oversample tick every final_value+1 clocks; must be static while a frame is in progress
- rd_en  input  1  consume holding register; ignored when rx_valid=0
- data_out  output  bit  received word (bit 0 = first data bit on line)
- rx_valid  output  1  holding register holds an unread word
- frame_err  output  1  one-cycle pulse: a stop bit sampled 0
- overrun_err  output  1  one-cycle pulse: good word dropped because holding register full
- busy  output  1  high from start-edge detect until return to IDLE

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: data_out=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0.
  - Internal: state=IDLE, synchronizer flops=1, tick counter=0, sample counter=0.
- Reset mid-frame aborts immediately; the partial word is never delivered.
- rx passes a 2-flop synchronizer; all decisions use the synchronized value `rxs`.
- Tick counter: free-running 0..final_value. Tick pulses in the cycle the count equals final_value, then wraps to 0. final_value=0 gives a tick every clock.
- State machine (s = oversample count 0..15, n = bit index):
  - IDLE: when rxs=0, go to START with s=0; busy=1 from the next cycle.
  - START: on each tick, s++. At s=7 (mid start bit):
    - rxs=0: go to DATA with s=0, n=0.
    - rxs=1: glitch. Return to IDLE with no flags and no delivery.
  - DATA: on each tick, s++. At s=15, shift rxs into the MSB of the shift register (LSB-first result) and set s=0. If n=bit-1, go to STOP; otherwise n++.
  - STOP: sb stop bits, each sampled at s=15. Any stop sample 0 latches a bad-stop flag. After the last stop sample, go to IDLE, busy=0, and deliver.
- Delivery (same clock as the final stop sample, visible the next cycle):
  - Bad stop: frame_err=1 for one cycle; word discarded; holding register untouched.
  - Good and rx_valid=0: data_out loaded, rx_valid=1.
  - Good, rx_valid=1 and rd_en=1 in the same cycle: new word loaded, rx_valid stays 1, no overrun.
  - Good, rx_valid=1 and rd_en=0: new word dropped, old data kept, overrun_err=1 for one cycle.
- rd_en with rx_valid=1 and no delivery: rx_valid clears next cycle; data_out holds its last value.
- Latency: rx_valid rises 1 clock after the tick that samples the last stop bit. That is about 3 clocks after the line's stop midpoint, including the synchronizer.
- A new start edge is accepted the cycle after returning to IDLE. Back-to-back frames with no idle gap must be received.
- A line held low (break) yields frame_err, then re-arms only after rxs returns to 1. IDLE waits for rxs=1 before accepting a falling edge.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined:
  - PARITY state inserted between DATA and STOP; one even-parity bit, sampled at s=15.
  - Extra output port parity_err (1 bit, reset 0).
  - On mismatch, parity_err pulses for one cycle at delivery and the word is discarded.
  - If a frame has both a parity error and a bad stop, both pulses assert.
- Undefined: no PARITY state, no parity_err port, frame length = 1+bit+sb bits.

Test Plan:
- final_value=0, bit=8, sb=2; drive 0xA5 at 16 clk/bit -> data_out=0xA5, rx_valid=1 ~3 clk after the 2nd stop midpoint; busy low in the same cycle; no error pulses.
- Low glitch of 5 clk on idle line (final_value=0) -> remains IDLE, busy returns 0, rx_valid=0, no flags.
- Send 0x3C with first stop bit forced 0 -> frame_err single-cycle pulse, rx_valid stays 0.
- Send 0x11 then 0x22 back-to-back without rd_en -> data_out=0x11, overrun_err one pulse. Repeat with rd_en asserted in the delivery cycle of 0x22 -> data_out=0x22, rx_valid=1, no overrun.
- final_value=253; send 0x5A; assert reset_n=0 mid-DATA, release, then send 0xC3 -> outputs 0 during reset, only 0xC3 delivered.
- PARITY_CHECK_EN defined: 0x07 with parity bit 1 -> accepted; with parity bit 0 -> parity_err pulse, rx_valid=0.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receive engine: 16x-oversampled deserialiser with a one-word holding register.
// Optional macro PARITY_CHECK_EN adds an even-parity bit and the parity_err output.
module uart_rx_frame #(
   parameter int value_bit = 10,
   parameter int data_bit  = 8,
   parameter int sb        = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx,
   input  logic [value_bit-1:0] final_value,
   input  logic                 rd_en,
   output logic [data_bit-1:0]  data_out,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun_err,
`ifdef PARITY_CHECK_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd4;
`ifdef PARITY_CHECK_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif

   logic                 rx_s1, rxs;
   logic [value_bit-1:0] tick_cnt;
   logic                 tick;
   logic [2:0]           state;
   logic [3:0]           s_cnt;
   logic [3:0]           n_cnt;
   logic                 k_cnt;
   logic                 armed;
   logic [data_bit-1:0]  shreg;
   logic                 stop_bad;
   logic                 last_stop;
   logic                 bad_stop_now;
   logic                 good;
`ifdef PARITY_CHECK_EN
   logic                 par_bad;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rxs   <= rx_s1;
      end
   end

   // >= rather than == keeps the counter bounded if final_value is lowered mid-count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    tick_cnt <= '0;
      else if (tick_cnt >= final_value) tick_cnt <= '0;
      else                             tick_cnt <= tick_cnt + 1'b1;
   end

   assign tick = (tick_cnt == final_value);
   assign busy = (state != IDLE);

   assign last_stop    = (state == STOP) && tick && (s_cnt == 4'd15) && (k_cnt == 1'(sb - 1));
   assign bad_stop_now = stop_bad | ~rxs;
`ifdef PARITY_CHECK_EN
   assign good = ~bad_stop_now & ~par_bad;
`else
   assign good = ~bad_stop_now;
`endif

   // armed blocks a held-low (break) line from retriggering until it has been seen high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         s_cnt    <= '0;
         n_cnt    <= '0;
         k_cnt    <= 1'b0;
         armed    <= 1'b0;
         shreg    <= '0;
         stop_bad <= 1'b0;
`ifdef PARITY_CHECK_EN
         par_bad  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (rxs) armed <= 1'b1;
               else if (armed) begin
                  state <= START;
                  s_cnt <= '0;
               end
            end
            START: if (tick) begin
               if (s_cnt == 4'd7) begin
                  s_cnt <= '0;
                  n_cnt <= '0;
                  state <= rxs ? IDLE : DATA;
               end else s_cnt <= s_cnt + 4'd1;
            end
            DATA: if (tick) begin
               if (s_cnt == 4'd15) begin
                  s_cnt <= '0;
                  shreg <= {rxs, shreg[data_bit-1:1]};
                  if (n_cnt == 4'(data_bit - 1)) begin
                     k_cnt    <= 1'b0;
                     stop_bad <= 1'b0;
`ifdef PARITY_CHECK_EN
                     state    <= PARITY;
`else
                     state    <= STOP;
`endif
                  end else n_cnt <= n_cnt + 4'd1;
               end else s_cnt <= s_cnt + 4'd1;
            end
`ifdef PARITY_CHECK_EN
            PARITY: if (tick) begin
               if (s_cnt == 4'd15) begin
                  s_cnt   <= '0;
                  par_bad <= ^{shreg, rxs};
                  state   <= STOP;
               end else s_cnt <= s_cnt + 4'd1;
            end
`endif
            STOP: if (tick) begin
               if (s_cnt == 4'd15) begin
                  s_cnt <= '0;
                  if (!rxs) stop_bad <= 1'b1;
                  if (k_cnt == 1'(sb - 1)) begin
                     state <= IDLE;
                     armed <= rxs;
                  end else k_cnt <= k_cnt + 1'b1;
               end else s_cnt <= s_cnt + 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out    <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err  <= 1'b0;
`endif
      end else begin
         frame_err   <= last_stop & bad_stop_now;
         overrun_err <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err  <= last_stop & par_bad;
`endif
         if (last_stop && good) begin
            if (!rx_valid || rd_en) begin
               data_out <= shreg;
               rx_valid <= 1'b1;
            end else overrun_err <= 1'b1;
         end else if (rd_en) rx_valid <= 1'b0;
      end
   end

endmodule
